// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default sizing for the control-sequencer slice.
// Imported by the sequencer top and its helpers.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      WAIT_STEP,
      HALTED
   } seq_state_e;

   localparam int STEPS_DEF  = 8;
   localparam int BUS_W_DEF  = 32;
   localparam int EN_W_DEF   = 32;
   localparam int HOLD_W_DEF = 4;

endpackage

// File: rtl/onehot_check.sv
// Flags a word with at most one bit set (popcount <= 1).
module onehot_check #(
   parameter int W = 32
) (
   input  logic [W-1:0] vec,
   output logic         ok
);

   assign ok = ((vec & (vec - W'(1))) == '0);

endmodule

// File: rtl/ctrl_sequencer.sv
// Programmable timing-step sequencer driving bus-select and register enables.
// Supports per-step hold, single-step, halt and bus-contention blocking.
module ctrl_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int STEPS  = STEPS_DEF,
   parameter int BUS_W  = BUS_W_DEF,
   parameter int EN_W   = EN_W_DEF,
   parameter int HOLD_W = HOLD_W_DEF
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     prog_we,
   input  logic [$clog2(STEPS)-1:0] prog_addr,
   input  logic [BUS_W-1:0]         prog_bus,
   input  logic [EN_W-1:0]          prog_en,
   input  logic                     prog_last,
   input  logic                     start,
   input  logic                     step_mode,
   input  logic                     step_go,
   input  logic                     halt,
   input  logic [HOLD_W-1:0]        hold_cycles,
   output logic [BUS_W-1:0]         busSelect,
   output logic [EN_W-1:0]          enable,
   output logic [$clog2(STEPS)-1:0] step,
   output logic                     busy,
   output logic                     done,
   output logic                     contention
);

   localparam int AW = $clog2(STEPS);
   localparam logic [AW-1:0] LAST_IDX = AW'(STEPS - 1);
   localparam logic [STEPS-1:0] LAST_RST = {1'b1, {(STEPS-1){1'b0}}};

   seq_state_e        state_q, state_d, ret_q, ret_d, nst;
   logic [AW-1:0]     step_q, step_d, nstep;
   logic [HOLD_W-1:0] cnt_q, cnt_d, ncnt, hold_q, hold_d;
   logic              load_q, load_d;
   logic [BUS_W-1:0]  bus_q, bus_d, sel_bus;
   logic [EN_W-1:0]   en_q, en_d;
   logic              done_q, done_d, cont_q, cont_d;
   logic              issue, clr_cont, fin, seq, last_step, bus_ok;

   logic [BUS_W-1:0]  tab_bus_q [STEPS];
   logic [EN_W-1:0]   tab_en_q  [STEPS];
   logic [STEPS-1:0]  tab_last_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < STEPS; i++) begin
            tab_bus_q[i] <= '0;
            tab_en_q[i]  <= '0;
         end
         tab_last_q <= LAST_RST;
      end else if (prog_we && state_q == IDLE) begin
         tab_bus_q[prog_addr]  <= prog_bus;
         tab_en_q[prog_addr]   <= prog_en;
         tab_last_q[prog_addr] <= prog_last;
      end
   end

   assign last_step = tab_last_q[step_q] || (step_q == LAST_IDX);

   // Work out where the sequence would go; halt then parks that target.
   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      step_d   = step_q;
      cnt_d    = cnt_q;
      hold_d   = hold_q;
      load_d   = 1'b0;
      done_d   = 1'b0;
      issue    = 1'b0;
      clr_cont = 1'b0;
      nst      = state_q;
      nstep    = step_q;
      ncnt     = cnt_q;
      fin      = 1'b0;
      seq      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && !halt) begin
               state_d  = RUN;
               step_d   = '0;
               cnt_d    = '0;
               hold_d   = hold_cycles;
               load_d   = 1'b1;
               clr_cont = 1'b1;
            end
         end
         RUN: begin
            seq = 1'b1;
            nst = RUN;
            if (load_q) begin
               ncnt = '0;
            end else if (cnt_q != hold_q) begin
               ncnt = cnt_q + HOLD_W'(1);
            end else if (last_step) begin
               fin = 1'b1;
            end else if (step_mode) begin
               nst = WAIT_STEP;
            end else begin
               nstep = step_q + AW'(1);
               ncnt  = '0;
            end
         end
         WAIT_STEP: begin
            seq = 1'b1;
            if (step_go) begin
               nst   = RUN;
               nstep = step_q + AW'(1);
               ncnt  = '0;
            end
         end
         HALTED: begin
            if (!halt) begin
               state_d = ret_q;
               cnt_d   = '0;
               issue   = (ret_q == RUN);
            end
         end
      endcase
      if (fin) begin
         state_d = IDLE;
         done_d  = 1'b1;
      end else if (seq && halt) begin
         state_d = HALTED;
         ret_d   = nst;
         step_d  = nstep;
      end else if (seq) begin
         state_d = nst;
         step_d  = nstep;
         cnt_d   = ncnt;
         issue   = (nst == RUN);
      end
   end

   assign sel_bus = tab_bus_q[step_d];

   onehot_check #(
      .W (BUS_W)
   ) u_onehot (
      .vec (sel_bus),
      .ok  (bus_ok)
   );

   always_comb begin
      bus_d  = '0;
      en_d   = '0;
      cont_d = clr_cont ? 1'b0 : cont_q;
      if (issue) begin
         en_d = tab_en_q[step_d];
         if (bus_ok) begin
            bus_d = sel_bus;
         end else begin
            cont_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         ret_q   <= IDLE;
         step_q  <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         load_q  <= 1'b0;
         bus_q   <= '0;
         en_q    <= '0;
         done_q  <= 1'b0;
         cont_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         load_q  <= load_d;
         bus_q   <= bus_d;
         en_q    <= en_d;
         done_q  <= done_d;
         cont_q  <= cont_d;
      end
   end

   assign busSelect  = bus_q;
   assign enable     = en_q;
   assign step       = step_q;
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign contention = cont_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed, table-driven bench for ctrl_sequencer.
module tb_ctrl_sequencer;
   import cpu_ctrl_pkg::*;

   logic        clk, clr;
   logic        prog_we, prog_last, start, step_mode, step_go, halt;
   logic [2:0]  prog_addr;
   logic [31:0] prog_bus, prog_en;
   logic [3:0]  hold_cycles;
   logic [31:0] busSelect, enable;
   logic [2:0]  step;
   logic        busy, done, contention;

   ctrl_sequencer #(
      .STEPS (8), .BUS_W (32), .EN_W (32), .HOLD_W (4)
   ) dut (
      .clk (clk), .clr (clr),
      .prog_we (prog_we), .prog_addr (prog_addr),
      .prog_bus (prog_bus), .prog_en (prog_en),
      .prog_last (prog_last), .start (start),
      .step_mode (step_mode), .step_go (step_go),
      .halt (halt), .hold_cycles (hold_cycles),
      .busSelect (busSelect), .enable (enable),
      .step (step), .busy (busy), .done (done),
      .contention (contention)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] B0 = 32'h0010_0000;
   localparam logic [31:0] E0 = 32'h0204_0000;
   localparam logic [31:0] B1 = 32'h0008_0000;
   localparam logic [31:0] E1 = 32'h0030_0000;
   localparam logic [31:0] B2 = 32'h0020_0000;
   localparam logic [31:0] E2 = 32'h0100_0000;

   typedef struct {
      logic        st, hl, sm, go, pw;
      logic [31:0] bus, en;
      logic [2:0]  stp;
      logic        bsy, dn, ct;
   } vec_t;

   vec_t vt[$];
   int checks = 0;
   int errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [69:0] got,
                      input logic [69:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   function automatic logic [69:0] outs();
      return {busSelect, enable, step, busy, done, contention};
   endfunction

   task automatic add(input logic st, hl, sm, go, pw,
                      input logic [31:0] b, e, input logic [2:0] s,
                      input logic bsy, dn, ct);
      vt.push_back('{st, hl, sm, go, pw, b, e, s, bsy, dn, ct});
   endtask

   task automatic play(input string tag);
      foreach (vt[i]) begin
         start     = vt[i].st;
         halt      = vt[i].hl;
         step_mode = vt[i].sm;
         step_go   = vt[i].go;
         prog_we   = vt[i].pw;
         if (vt[i].pw) begin
            prog_addr = 3'd1;
            prog_bus  = 32'h20;
            prog_en   = 32'h20;
            prog_last = 1'b1;
         end
         tick();
         chk($sformatf("%s row %0d", tag, i), outs(),
             {vt[i].bus, vt[i].en, vt[i].stp,
              vt[i].bsy, vt[i].dn, vt[i].ct});
      end
      {start, halt, step_mode, step_go, prog_we, prog_last} = '0;
      prog_addr = '0;
      prog_bus  = '0;
      prog_en   = '0;
   endtask

   task automatic prog(input logic [2:0] a, input logic [31:0] b, e,
                       input logic l);
      prog_we = 1'b1; prog_addr = a; prog_bus = b;
      prog_en = e; prog_last = l;
      tick();
      prog_we = 1'b0;
   endtask

   // Basic three-step run; pwr marks a row that pokes start+prog_we.
   task automatic add_plain(input int pwr, input bit ct);
      logic [31:0] b, e;
      vt.delete();
      add(1, 0, 0, 0, 0, '0, '0, 3'd0, 1, 0, 0);
      for (int i = 1; i <= 6; i++) begin
         case ((i - 1) / 2)
            0: begin b = B0; e = E0; end
            1: begin b = ct ? '0 : B1; e = E1; end
            default: begin b = B2; e = E2; end
         endcase
         add(i == pwr, 0, 0, 0, i == pwr, b, e, 3'((i - 1) / 2),
             1, 0, ct && i >= 3);
      end
      add(0, 0, 0, 0, 0, '0, '0, 3'd2, 0, 1, ct);
      add(0, 0, 0, 0, 0, '0, '0, 3'd2, 0, 0, ct);
   endtask

   initial begin
      clr = 1'b0;
      {start, halt, step_mode, step_go, prog_we, prog_last} = '0;
      prog_addr = '0; prog_bus = '0; prog_en = '0;
      hold_cycles = 4'd1;
      tick();
      chk("reset outs", outs(), '0);
      tick();
      clr = 1'b1;
      tick();
      chk("post reset", outs(), '0);

      prog(3'd0, B0, E0, 1'b0);
      prog(3'd1, B1, E1, 1'b0);
      prog(3'd2, B2, E2, 1'b1);

      add_plain(0, 1'b0);
      play("basic");

      add_plain(2, 1'b0);
      play("busy_ignore");

      vt.delete();
      add(1, 0, 0, 0, 0, '0, '0, 3'd0, 1, 0, 0);
      add(0, 0, 0, 0, 0, B0, E0, 3'd0, 1, 0, 0);
      add(0, 0, 0, 0, 0, B0, E0, 3'd0, 1, 0, 0);
      for (int i = 0; i < 3; i++)
         add(0, 1, 0, 0, 0, '0, '0, 3'd1, 1, 0, 0);
      add(0, 0, 0, 0, 0, B1, E1, 3'd1, 1, 0, 0);
      add(0, 0, 0, 0, 0, B1, E1, 3'd1, 1, 0, 0);
      add(0, 0, 0, 0, 0, B2, E2, 3'd2, 1, 0, 0);
      add(0, 0, 0, 0, 0, B2, E2, 3'd2, 1, 0, 0);
      add(0, 0, 0, 0, 0, '0, '0, 3'd2, 0, 1, 0);
      play("halt");

      vt.delete();
      add(1, 0, 1, 0, 0, '0, '0, 3'd0, 1, 0, 0);
      add(0, 0, 1, 0, 0, B0, E0, 3'd0, 1, 0, 0);
      add(0, 0, 1, 0, 0, B0, E0, 3'd0, 1, 0, 0);
      add(0, 0, 1, 0, 0, '0, '0, 3'd0, 1, 0, 0);
      add(0, 0, 1, 0, 0, '0, '0, 3'd0, 1, 0, 0);
      add(0, 0, 1, 1, 0, B1, E1, 3'd1, 1, 0, 0);
      add(0, 0, 1, 0, 0, B1, E1, 3'd1, 1, 0, 0);
      add(0, 0, 1, 0, 0, '0, '0, 3'd1, 1, 0, 0);
      add(0, 0, 1, 1, 0, B2, E2, 3'd2, 1, 0, 0);
      add(0, 0, 1, 0, 0, B2, E2, 3'd2, 1, 0, 0);
      add(0, 0, 1, 0, 0, '0, '0, 3'd2, 0, 1, 0);
      play("single_step");

      start = 1'b1; halt = 1'b1;
      tick();
      start = 1'b0; halt = 1'b0;
      chk("halt beats start", {69'd0, busy}, 70'd0);
      tick();
      chk("halt start idle", {69'd0, busy}, 70'd0);

      prog(3'd1, B0 | B1, E1, 1'b0);
      add_plain(0, 1'b1);
      play("contention");
      add_plain(0, 1'b1);
      play("contention_rerun");
      prog(3'd1, B1, E1, 1'b0);

      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk("pre clr T1", {busSelect, enable}, {6'd0, B1, E1});
      #2 clr = 1'b0;
      #1 chk("clr immediate", outs(), '0);
      tick();
      clr = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("no done after clr %0d", i),
             {68'd0, busy, done}, 70'd0);
      end

      hold_cycles = 4'd0;
      vt.delete();
      add(1, 0, 0, 0, 0, '0, '0, 3'd0, 1, 0, 0);
      for (int i = 1; i <= 8; i++)
         add(0, 0, 0, 0, 0, '0, '0, 3'(i - 1), 1, 0, 0);
      add(0, 0, 0, 0, 0, '0, '0, 3'd7, 0, 1, 0);
      add(0, 0, 0, 0, 0, '0, '0, 3'd7, 0, 0, 0);
      play("cleared_table");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
